// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle RV32I control FSM with bus handshakes, timeout watchdog and instret counter
module core_sequencer #(
  parameter int TIMEOUT_W = 8,
  parameter int INSTRET_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  output logic                 o_imem_valid,
  input  logic                 i_imem_ready,
  output logic                 o_ir_load,
  input  logic                 i_inst_illegal,
  input  logic                 i_inst_ecall,
  input  logic                 i_inst_ebreak,
  input  logic                 i_inst_load,
  input  logic                 i_inst_store,
  input  logic                 i_writes_rd,
  input  logic [4:0]           i_a_rd,
  output logic                 o_dmem_valid,
  output logic                 o_dmem_we,
  input  logic                 i_dmem_ready,
  output logic                 o_rf_we,
  output logic                 o_pc_load,
  output logic                 o_pc_sel_trap,
  output logic                 o_trap,
  output logic [3:0]           o_trap_cause,
  output logic [INSTRET_W-1:0] o_instret,
  output logic [2:0]           o_state
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t state, next;
  logic [TIMEOUT_W-1:0] waited;
  logic [3:0] cause_next;
  logic timed_out;
  // the current ready-less cycle is the last one allowed, so the access faults now
  assign timed_out = waited == {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  assign o_state = state;
  always_comb begin
    next = IDLE;
    cause_next = 4'd0;
    o_imem_valid = 1'b0;
    o_ir_load = 1'b0;
    o_dmem_valid = 1'b0;
    o_dmem_we = 1'b0;
    o_rf_we = 1'b0;
    o_pc_load = 1'b0;
    o_pc_sel_trap = 1'b0;
    o_trap = 1'b0;
    case (state)
      IDLE: next = FETCH;
      FETCH: begin
        o_imem_valid = 1'b1;
        o_ir_load = i_imem_ready;
        next = i_imem_ready ? DECODE : timed_out ? TRAP : FETCH;
        cause_next = 4'd1;
      end
      DECODE: begin
        next = (i_inst_illegal | i_inst_ebreak | i_inst_ecall) ? TRAP : EXEC;
        cause_next = i_inst_illegal ? 4'd2 : i_inst_ebreak ? 4'd3 : 4'd11;
      end
      EXEC: next = (i_inst_load | i_inst_store) ? MEM : WB;
      MEM: begin
        o_dmem_valid = 1'b1;
        o_dmem_we = i_inst_store;
        next = i_dmem_ready ? WB : timed_out ? TRAP : MEM;
        cause_next = i_inst_store ? 4'd7 : 4'd5;
      end
      WB: begin
        o_rf_we = i_writes_rd & (i_a_rd != 5'd0);
        o_pc_load = 1'b1;
        next = FETCH;
      end
      TRAP: begin
        o_trap = 1'b1;
        o_pc_load = 1'b1;
        o_pc_sel_trap = 1'b1;
        next = FETCH;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      waited <= '0;
      o_instret <= '0;
      o_trap_cause <= 4'd0;
    end else begin
      state <= next;
      waited <= (next != state) ? '0 : waited + 1'b1;
      if (next == TRAP) o_trap_cause <= cause_next;
      if (state == WB) o_instret <= o_instret + 1'b1;
    end
  end
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences instruction fetch, decode, execute, data-memory access, writeback and trap entry around the combinational instruction decoder and the datapath.
- Owns the imem/dmem valid/ready handshakes, a bus-timeout watchdog, and the retired-instruction counter.
- The PC register itself lives in the datapath; this block only commands PC loads.

Parameters:
TIMEOUT_W, 8, width of wait counter; a bus access faults after 2^TIMEOUT_W-1 cycles without ready.
INSTRET_W, 32, width of retired-instruction counter.

Ports:
i_clk  in  1  core clock; all state changes on rising edge
i_reset  in  1  synchronous, active-high reset
o_imem_valid  out  1  instruction fetch request
i_imem_ready  in  1  fetch data valid this cycle
o_ir_load  out  1  latch imem data into instruction register
i_inst_illegal  in  1  decoder illegal flag
i_inst_ecall  in  1  decoder ecall flag
i_inst_ebreak  in  1  decoder ebreak flag
i_inst_load  in  1  any load instruction
i_inst_store  in  1  any store instruction
i_writes_rd  in  1  instruction writes rd (lui/auipc/jal/jalr/loads/op/opimm/csr)
i_a_rd  in  5  destination register address
o_dmem_valid  out  1  data access request
o_dmem_we  out  1  data access is a write
i_dmem_ready  in  1  data access complete this cycle
o_rf_we  out  1  register-file write enable
o_pc_load  out  1  datapath loads next PC
o_pc_sel_trap  out  1  with o_pc_load: load trap vector instead of next PC
o_trap  out  1  one-cycle trap-entry pulse
o_trap_cause  out  4  RISC-V mcause code, held until next trap
o_instret  out  INSTRET_W  retired-instruction count
o_state  out  3  current state, for debug

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. Unused encoding 7 goes to IDLE.
- Reset (sync, wins over everything, including mid-handshake):
  - state=IDLE; wait counter=0; o_instret=0; o_trap_cause=0.
  - All outputs deasserted from the first cycle after the reset edge.
  - An outstanding valid is dropped without waiting for ready.
- Output decoding: all control outputs are combinational from state and inputs (Mealy); no registered outputs except o_trap_cause and o_instret.
- IDLE: one cycle, no outputs -> FETCH.
- FETCH:
  - o_imem_valid=1, held continuously until ready.
  - i_imem_ready=1 -> o_ir_load=1 in the same cycle -> DECODE.
  - Each cycle without ready increments the wait counter. When the counter equals 2^TIMEOUT_W-1 and ready is still low -> TRAP, cause=1.
  - Ready on the timeout cycle wins: no fault.
- DECODE: one cycle, priority order:
  - illegal -> TRAP, cause=2
  - ebreak -> TRAP, cause=3
  - ecall -> TRAP, cause=11
  - else -> EXEC
- EXEC: one cycle. load|store -> MEM; else -> WB.
- MEM:
  - o_dmem_valid=1; o_dmem_we=i_inst_store. Both stable until ready.
  - ready -> WB.
  - Timeout as in FETCH -> TRAP with cause=5 for a load, 7 for a store.
- Wait counter: cleared on every state transition.
- WB: one cycle.
  - o_rf_we = i_writes_rd & (i_a_rd!=0).
  - o_pc_load=1, o_pc_sel_trap=0.
  - o_instret increments, wrapping modulo 2^INSTRET_W.
  - -> FETCH.
- TRAP: one cycle.
  - o_trap=1, o_pc_load=1, o_pc_sel_trap=1.
  - o_trap_cause is registered on entry.
  - No register write; o_instret unchanged.
  - -> FETCH.
- Invariants:
  - Never both o_imem_valid and o_dmem_valid.
  - o_rf_we only in WB.
  - A ready received outside FETCH/MEM is ignored.

Test Plan:
- Reset, ALU op: i_writes_rd=1, i_a_rd=5, imem ready after 2 cycles -> states 0,1,1,1,2,3,5,1. o_rf_we=1 only in WB; o_instret=1.
- Load: i_inst_load=1, dmem ready after 3 cycles -> o_dmem_valid high 4 cycles with o_dmem_we=0, then WB with o_rf_we=1. Repeat as store with i_writes_rd=0 -> o_dmem_we=1, o_rf_we=0.
- Illegal plus ecall both set in DECODE -> TRAP, o_trap pulse 1 cycle, o_trap_cause=2, o_pc_sel_trap=1, o_instret unchanged. Same test with ebreak only -> cause=3.
- Fetch timeout, TIMEOUT_W=3, ready never asserted -> TRAP exactly 7 cycles after FETCH entry, cause=1. Ready on 7th cycle -> DECODE, no trap.
- i_a_rd=0 with i_writes_rd=1 -> o_rf_we stays 0 in WB. Assert i_reset during MEM wait -> next cycle o_dmem_valid=0, state=IDLE, o_instret=0.
- INSTRET_W=4, retire 16 instructions -> o_instret wraps 15 -> 0.
